// File: rtl/tc_pkg.sv
// Shared types and helpers for the phase timer block.
package tc_pkg;

  // Countdown controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } phase_timer_state_t;

  // Clock cycles per tick for a given clock and tick rate.
  function automatic int unsigned prescale_of(input int unsigned clk_hz,
                                              input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-PRESCALE counter. The tick output is the combinational
// wrap strobe: high during the cycle whose rising edge takes the count from
// PRESCALE-1 back to 0. The parent registers it so the visible tick lines up
// with the edge that performs the wrap.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Loadable tick-based countdown timer with pause, abort and expiry pulse.
//
// Edge priority: reset > abort > load > pause > tick-decrement.
// The prescaler is frozen while enable is low or while the FSM sits in HOLD.
// On the edge where pause is first seen in RUN the FSM moves to HOLD and no
// decrement happens on that edge, even if the prescaler wraps there.
// state_dbg mirrors the registered FSM state for observation.
module phase_timer
  import tc_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               load,
  input  logic [CNT_W-1:0]   load_val,
  input  logic               pause,
  input  logic               abort,
  output logic               tick,
  output logic [CNT_W-1:0]   remaining,
  output logic               busy,
  output logic               done,
  output phase_timer_state_t state_dbg
);

  localparam int unsigned PRESCALE = prescale_of(CLK_HZ, TICK_HZ);

  if (((CLK_HZ % TICK_HZ) != 0) || (PRESCALE < 2)) begin : g_bad_cfg
    $error("phase_timer: CLK_HZ must be a multiple of TICK_HZ giving PRESCALE >= 2");
  end

  phase_timer_state_t state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic presc_en;
  logic presc_clear;
  logic wrap;

  // An abort in the same cycle cancels the load, so it must not clear the
  // prescaler either.
  assign presc_clear = load & ~abort;
  assign presc_en    = enable & (state_q != HOLD);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (presc_en),
    .clear  (presc_clear),
    .tick   (wrap)
  );

  // Next-state, countdown and pulse computation in priority order.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (load) begin
      rem_d = load_val;
      if (load_val != '0) begin
        state_d = RUN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (pause) begin
            state_d = HOLD;
          end else if (wrap && (rem_q != '0)) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        HOLD: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
    tick_d = wrap;
    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tick      = tick_q;
  assign remaining = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: doc/phase_timer.md
PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, tick rate in Hz; PRESCALE = CLK_HZ/TICK_HZ.
REQ-003 Parameter CNT_W, default 8, width of the loadable countdown in ticks.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  prescaler run enable; low freezes the prescaler and the countdown.
REQ-007 load  input  1  one-cycle strobe; starts a countdown from load_val.
REQ-008 load_val  input  CNT_W  countdown length in ticks, sampled when load=1.
REQ-009 pause  input  1  level; holds the countdown and prescaler while high.
REQ-010 abort  input  1  one-cycle strobe; cancels the countdown without done.
REQ-011 tick  output  1  one-cycle pulse every PRESCALE enabled, unpaused cycles.
REQ-012 remaining  output  CNT_W  ticks left in the current countdown.
REQ-013 busy  output  1  high while state is RUN or HOLD.
REQ-014 done  output  1  one-cycle pulse on countdown expiry.

Function
REQ-015 Elaboration SHALL fail if CLK_HZ % TICK_HZ != 0 or PRESCALE < 2.
REQ-016 Prescaler width SHALL be $clog2(PRESCALE); it counts 0..PRESCALE-1, then wraps to 0.
REQ-017 The prescaler advances only when enable=1 and state != HOLD; otherwise it holds and tick=0.
REQ-018 tick SHALL be registered high for exactly one cycle on the edge where the prescaler wraps from PRESCALE-1 to 0.
REQ-019 With enable held high from reset release, the first tick SHALL be visible PRESCALE cycles after the first non-reset edge.
REQ-020 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-021 Accepted load SHALL clear the prescaler to 0 and set remaining=load_val.
REQ-022 A load with load_val>0 SHALL enter RUN from any state, restarting a countdown already in progress.
REQ-023 A load with load_val=0 SHALL keep or return the FSM to IDLE and pulse done on the next cycle.
REQ-024 In RUN, remaining SHALL decrement on the same edge that registers tick=1.
REQ-025 When remaining goes 1->0, done=1 and the FSM returns to IDLE on the same edge; busy=0 from that cycle.
REQ-026 From load of N>0 with enable high and no pause, done SHALL be visible exactly N*PRESCALE cycles after the load edge.
REQ-027 pause=1 in RUN SHALL move the FSM to HOLD; pause=0 in HOLD SHALL return it to RUN, resuming the prescaler count unchanged.
REQ-028 pause SHALL be ignored in IDLE, where the prescaler free-runs under enable.
REQ-029 abort SHALL force IDLE and remaining=0, with done=0; abort in IDLE SHALL have no effect beyond remaining=0.
REQ-030 Input priority per edge SHALL be reset > abort > load > pause > tick-decrement.
REQ-031 remaining SHALL never wrap below 0; no decrement occurs in IDLE or HOLD.

Reset
REQ-032 On reset, state=IDLE, prescaler=0, remaining=0, tick=0, busy=0 and done=0.
REQ-033 Reset asserted mid-countdown SHALL abort the countdown with no done pulse.

Structure
REQ-034 State enum phase_timer_state_t (IDLE, RUN, HOLD) SHALL live in shared package tc_pkg.
REQ-035 The prescaler SHALL be the sub-module tick_prescaler, with ports clk, reset, enable, clear and tick and parameter PRESCALE.
REQ-036 The FSM and countdown register SHALL reside in phase_timer.

Verification (CLK_HZ=10, TICK_HZ=1, CNT_W=8, so PRESCALE=10)
REQ-037 Bench SHALL cover: enable=1 from reset -> tick at cycles 10, 20 and 30, each one cycle wide.
REQ-038 Bench SHALL cover: load, load_val=3 -> busy=1, remaining steps 3,2,1,0, and done pulses exactly 30 cycles after the load edge.
REQ-039 Bench SHALL cover: load 3, pause high for 7 cycles mid-period -> done is delayed to 37 cycles and remaining is unchanged during the pause.
REQ-040 Bench SHALL cover: load 5, abort at cycle 22 -> remaining=0, busy=0 and no done pulse; load 0 -> done pulses 1 cycle later and busy stays 0.
REQ-041 Bench SHALL cover: load and abort on the same cycle -> abort wins; reset at cycle 15 of a load-4 countdown -> all outputs return to reset values.
